// File: rtl/adc_trig_capture_if.sv
// AXI4-Stream beat channel carrying {Ch1, Ch0} capture samples.
// The master drives data/valid/last; the slave drives ready.
interface adc_trig_capture_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/adc_trig_capture.sv
// Triggered two-channel ADC capture into a circular BRAM buffer,
// then oldest-first readout on an AXI4-Stream master.
module adc_trig_capture #(
  parameter int AdcBits   = 14,
  parameter int DepthLog2 = 10
) (
  input  logic                 AdcFrmClk,
  input  logic                 AdcRst_n,
  input  logic                 AdcDataValid,
  input  logic [15:0]          AdcDataCh0,
  input  logic [15:0]          AdcDataCh1,
  input  logic                 Arm,
  input  logic                 ForceTrig,
  input  logic                 TrigSrc,
  input  logic                 TrigEdge,
  input  logic [15:0]          TrigLevel,
  input  logic [DepthLog2-1:0] PreTrigLen,
  adc_trig_capture_if.master   m_axis,
  output logic                 Busy,
  output logic                 Triggered
);

  localparam int Depth = 2 ** DepthLog2;

  typedef logic [DepthLog2-1:0] ptr_t;
  typedef logic [DepthLog2:0]   rcnt_t;
  typedef logic [AdcBits-1:0]   smp_t;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_TRIG,
    POST,
    READOUT
  } state_e;

  state_e state_q, state_d;

  ptr_t  wr_ptr_q, wr_ptr_d;
  ptr_t  cnt_q, cnt_d;
  smp_t  prev_q, prev_d;
  logic  prev_ok_q, prev_ok_d;
  logic  trig_q, trig_d;

  logic  src_q, src_d;
  logic  edge_q, edge_d;
  smp_t  lvl_q, lvl_d;
  ptr_t  pre_q, pre_d;

  ptr_t  rd_ptr_q, rd_ptr_d;
  rcnt_t rd_cnt_q, rd_cnt_d;
  logic  pend_q, pend_d;
  logic  pend_last_q, pend_last_d;

  logic        out_v_q, out_v_d;
  logic [31:0] out_d_q, out_d_d;
  logic        out_l_q, out_l_d;
  logic        sk_v_q, sk_v_d;
  logic [31:0] sk_d_q, sk_d_d;
  logic        sk_l_q, sk_l_d;

  logic [31:0] mem_q [Depth];
  logic [31:0] ram_q;

  smp_t     cur;
  logic     rise, fall, hit;
  logic     capturing, we, ren, pop, go_rd;
  ptr_t     cnt_inc;
  logic [1:0] occ, occ_left;

  logic unused_lvl;
  assign unused_lvl = ^TrigLevel[15:AdcBits];

  assign cur = src_q ? AdcDataCh1[AdcBits-1:0]
                     : AdcDataCh0[AdcBits-1:0];

  assign rise = prev_ok_q && (prev_q < lvl_q)
             && (cur >= lvl_q);
  assign fall = prev_ok_q && (prev_q > lvl_q)
             && (cur <= lvl_q);
  assign hit  = ForceTrig || (edge_q ? fall : rise);

  assign capturing = (state_q == PRE)
                  || (state_q == WAIT_TRIG)
                  || (state_q == POST);
  assign we      = AdcRst_n && capturing && AdcDataValid;
  assign cnt_inc = cnt_q + 1'b1;
  assign pop     = out_v_q && m_axis.tready;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    prev_d    = prev_q;
    prev_ok_d = prev_ok_q;
    trig_d    = trig_q;
    src_d     = src_q;
    edge_d    = edge_q;
    lvl_d     = lvl_q;
    pre_d     = pre_q;
    go_rd     = 1'b0;

    if (we) begin
      wr_ptr_d  = wr_ptr_q + 1'b1;
      prev_d    = cur;
      prev_ok_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (Arm) begin
          src_d     = TrigSrc;
          edge_d    = TrigEdge;
          lvl_d     = TrigLevel[AdcBits-1:0];
          pre_d     = PreTrigLen;
          cnt_d     = '0;
          prev_ok_d = 1'b0;
          trig_d    = 1'b0;
          state_d   = (PreTrigLen == '0) ? WAIT_TRIG
                                         : PRE;
        end
      end
      PRE: begin
        if (we) begin
          if (cnt_inc == pre_q) begin
            cnt_d   = '0;
            state_d = WAIT_TRIG;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      WAIT_TRIG: begin
        if (we && hit) begin
          trig_d = 1'b1;
          cnt_d  = '0;
          // No post samples left when PreTrigLen = Depth-1
          if (pre_q == ptr_t'(Depth - 1)) begin
            state_d = READOUT;
            go_rd   = 1'b1;
          end else begin
            state_d = POST;
          end
        end
      end
      POST: begin
        if (we) begin
          if (cnt_inc == ~pre_q) begin
            state_d = READOUT;
            go_rd   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      READOUT: begin
        if (pop && out_l_q) begin
          state_d = IDLE;
          trig_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Two-slot readout: output register plus skid, with one read in flight
  assign occ = 2'(out_v_q) + 2'(sk_v_q) + 2'(pend_q);
  assign occ_left = occ - 2'(pop);
  assign ren = AdcRst_n
            && (state_q == READOUT)
            && (rd_cnt_q != rcnt_t'(Depth))
            && (occ_left < 2'd2);

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    rd_cnt_d    = rd_cnt_q;
    pend_d      = 1'b0;
    pend_last_d = 1'b0;
    out_v_d     = out_v_q;
    out_d_d     = out_d_q;
    out_l_d     = out_l_q;
    sk_v_d      = sk_v_q;
    sk_d_d      = sk_d_q;
    sk_l_d      = sk_l_q;

    if (go_rd) begin
      rd_ptr_d = wr_ptr_d;
      rd_cnt_d = '0;
    end else if (ren) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      rd_cnt_d    = rd_cnt_q + 1'b1;
      pend_d      = 1'b1;
      pend_last_d = (rd_cnt_q == rcnt_t'(Depth - 1));
    end

    if (!out_v_q || pop) begin
      if (sk_v_q) begin
        out_v_d = 1'b1;
        out_d_d = sk_d_q;
        out_l_d = sk_l_q;
        sk_v_d  = pend_q;
        sk_d_d  = ram_q;
        sk_l_d  = pend_q && pend_last_q;
      end else begin
        out_v_d = pend_q;
        out_d_d = ram_q;
        out_l_d = pend_q && pend_last_q;
      end
    end else if (pend_q) begin
      sk_v_d = 1'b1;
      sk_d_d = ram_q;
      sk_l_d = pend_last_q;
    end
  end

  always_ff @(posedge AdcFrmClk) begin
    if (!AdcRst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      prev_q      <= '0;
      prev_ok_q   <= 1'b0;
      trig_q      <= 1'b0;
      src_q       <= 1'b0;
      edge_q      <= 1'b0;
      lvl_q       <= '0;
      pre_q       <= '0;
      rd_ptr_q    <= '0;
      rd_cnt_q    <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      out_v_q     <= 1'b0;
      out_d_q     <= '0;
      out_l_q     <= 1'b0;
      sk_v_q      <= 1'b0;
      sk_d_q      <= '0;
      sk_l_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      prev_ok_q   <= prev_ok_d;
      trig_q      <= trig_d;
      src_q       <= src_d;
      edge_q      <= edge_d;
      lvl_q       <= lvl_d;
      pre_q       <= pre_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_cnt_q    <= rd_cnt_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      out_v_q     <= out_v_d;
      out_d_q     <= out_d_d;
      out_l_q     <= out_l_d;
      sk_v_q      <= sk_v_d;
      sk_d_q      <= sk_d_d;
      sk_l_q      <= sk_l_d;
    end
  end

  always_ff @(posedge AdcFrmClk) begin
    if (we) begin
      mem_q[wr_ptr_q] <= {AdcDataCh1, AdcDataCh0};
    end
    if (ren) begin
      ram_q <= mem_q[rd_ptr_q];
    end
  end

  assign m_axis.tdata  = out_d_q;
  assign m_axis.tvalid = out_v_q;
  assign m_axis.tlast  = out_l_q;

  assign Busy      = (state_q != IDLE);
  assign Triggered = trig_q;

endmodule

// File: tb/tb_adc_trig_capture.sv
// Directed bench for adc_trig_capture at DepthLog2 = 4.
// Ramp sources with hand-derived expected packets.
module tb_adc_trig_capture;
  localparam int DL2   = 4;
  localparam int Depth = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, vld, arm, force_t, src, edg;
  logic [15:0]    ch0, ch1, lvl;
  logic [DL2-1:0] pre;
  logic           busy, trig;

  adc_trig_capture_if axis();

  adc_trig_capture #(
    .AdcBits  (14),
    .DepthLog2(DL2)
  ) dut (
    .AdcFrmClk   (clk),
    .AdcRst_n    (rst_n),
    .AdcDataValid(vld),
    .AdcDataCh0  (ch0),
    .AdcDataCh1  (ch1),
    .Arm         (arm),
    .ForceTrig   (force_t),
    .TrigSrc     (src),
    .TrigEdge    (edg),
    .TrigLevel   (lvl),
    .PreTrigLen  (pre),
    .m_axis      (axis),
    .Busy        (busy),
    .Triggered   (trig)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] sval;
  int          sstep;
  bit          tog;
  bit          drv_v;

  logic [31:0] beats [32];
  int          nb, nlast, last_idx;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    vld = drv_v;
    ch0 = drv_v ? sval : 16'hBAD0;
    ch1 = drv_v ? ~sval : 16'h0BAD;
  endtask

  // Source advances only past samples that were presented as valid
  task automatic tick();
    @(posedge clk);
    #1;
    if (drv_v) sval = sval + 16'(sstep);
    drv_v = tog ? ~drv_v : 1'b1;
    drive();
  endtask

  task automatic start(int s0, int step, bit t, bit v0);
    sval  = 16'(s0);
    sstep = step;
    tog   = t;
    drv_v = v0;
    drive();
  endtask

  task automatic arm_go(bit e, int level, int p);
    src = 1'b0;
    edg = e;
    lvl = 16'(level);
    pre = DL2'(p);
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic collect(int lowpct, int abort_at, int arm_at);
    bit          stall, done, armed;
    logic [32:0] hold;
    int          cyc;
    nb = 0; nlast = 0; last_idx = -1;
    stall = 0; armed = 0; hold = '0; cyc = 0;
    foreach (beats[i]) beats[i] = '0;
    forever begin
      if (nb == abort_at) break;
      axis.tready = ($urandom_range(0, 99) >= lowpct);
      if (nb == arm_at && !armed) begin
        arm = 1'b1;
        armed = 1;
      end
      if (axis.tvalid && axis.tready) begin
        if (nb == 0) chk("trig_in_rd", trig, 1);
        if (nb < 32) beats[nb] = axis.tdata;
        if (axis.tlast) begin
          nlast++;
          last_idx = nb;
        end
        nb++;
      end
      stall = axis.tvalid && !axis.tready;
      hold  = {axis.tlast, axis.tdata};
      done  = axis.tvalid && axis.tready && axis.tlast;
      tick();
      arm = 1'b0;
      if (stall) begin
        chk("stall_valid", axis.tvalid, 1);
        chk("stall_data", {axis.tlast, axis.tdata}, hold);
      end
      if (done) break;
      cyc++;
      if (cyc > 400) begin
        total++;
        bad++;
        $error("FAIL rd_timeout beats=%0d exp=%0d",
               nb, Depth);
        break;
      end
    end
    axis.tready = 1'b0;
  endtask

  task automatic verify(string tag, int base, int step);
    logic [15:0] e;
    chk({tag, "_nbeats"}, nb, Depth);
    chk({tag, "_nlast"}, nlast, 1);
    chk({tag, "_lastidx"}, last_idx, Depth - 1);
    for (int i = 0; i < Depth; i++) begin
      e = 16'(base + step * i);
      chk($sformatf("%s_beat%0d", tag, i),
          beats[i], {~e, e});
    end
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_trig_end"}, trig, 0);
    chk({tag, "_tvalid_end"}, axis.tvalid, 0);
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; force_t = 1'b0;
    src = 1'b0; edg = 1'b0; lvl = '0; pre = '0;
    axis.tready = 1'b0;
    start(0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_tvalid", axis.tvalid, 0);
    chk("rst_tlast", axis.tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_trig", trig, 0);
    rst_n = 1'b1;
    tick();

    // rising edge at 100, four pre-trigger samples
    start(0, 10, 0, 1);
    arm_go(0, 100, 4);
    chk("t1_busy", busy, 1);
    collect(0, -1, -1);
    verify("t1", 60, 10);

    // falling edge at 50 on a descending ramp
    start(200, -10, 0, 1);
    arm_go(1, 50, 4);
    collect(0, -1, -1);
    verify("t2", 90, -10);

    // first sample after Arm must not compare against stale prev
    start(50, -10, 0, 1);
    arm_go(1, 50, 0);
    repeat (3) tick();
    chk("t2b_no_first_trig", trig, 0);
    force_t = 1'b1;
    collect(0, -1, -1);
    force_t = 1'b0;
    verify("t2b", 10, -10);

    // gapped valid, forced trigger from Arm
    start(1000, 10, 1, 0);
    force_t = 1'b1;
    arm_go(0, 16000, 0);
    collect(0, -1, -1);
    force_t = 1'b0;
    verify("t3", 1000, 10);

    // back-pressure on readout
    start(0, 10, 0, 1);
    arm_go(0, 100, 4);
    collect(30, -1, -1);
    verify("t4", 60, 10);

    // reset in the middle of readout
    start(0, 10, 0, 1);
    arm_go(0, 100, 4);
    collect(0, 7, -1);
    chk("t5_tvalid_pre_rst", axis.tvalid, 1);
    rst_n = 1'b0;
    tick();
    chk("t5_tvalid_rst", axis.tvalid, 0);
    chk("t5_busy_rst", busy, 0);
    chk("t5_trig_rst", trig, 0);
    rst_n = 1'b1;
    tick();
    start(0, 10, 0, 1);
    arm_go(0, 100, 4);
    collect(0, -1, -1);
    verify("t5", 60, 10);

    // Arm and config changes after arming are ignored
    start(0, 10, 0, 1);
    arm_go(0, 100, 4);
    repeat (6) tick();
    lvl = 16'd150;
    pre = DL2'(2);
    edg = 1'b1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("t6_busy_wait", busy, 1);
    chk("t6_trig_wait", trig, 0);
    collect(0, -1, 5);
    verify("t6", 60, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
